// File: rtl/spi_cmd_router.sv
// rtl/spi_cmd_router.sv - opcode-framed SPI byte stream decoder for registers, FIFO channels and mode
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rx_data, rx_valid        received SPI byte and its one-cycle strobe
//   tx_data, tx_valid        registered response byte and its one-cycle load strobe
//   reg_addr/we/wdata/rdata  external control register access (rdata is combinational)
//   fifo_ch                  active channel index
//   fifo_we, fifo_wdata      one-hot FIFO push strobes and data
//   fifo_rd, fifo_rdata      one-hot FWFT pop strobes and per-channel head words
//   fifo_empty, fifo_full    per-channel status
//   mode                     mode register
//   busy                     command in progress
//   err_flags, err_clr       sticky errors [0] opcode/channel/addr [1] timeout [2] overflow [3] underflow
module spi_cmd_router #(
  parameter int NUM_REGS    = 16,
  parameter int REG_ADDR_W  = 4,
  parameter int NUM_CH      = 2,
  parameter int CH_W        = 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic                  reg_we,
  output logic [7:0]            reg_wdata,
  input  logic [7:0]            reg_rdata,
  output logic [CH_W-1:0]       fifo_ch,
  output logic [NUM_CH-1:0]     fifo_we,
  output logic [7:0]            fifo_wdata,
  output logic [NUM_CH-1:0]     fifo_rd,
  input  logic [8*NUM_CH-1:0]   fifo_rdata,
  input  logic [NUM_CH-1:0]     fifo_empty,
  input  logic [NUM_CH-1:0]     fifo_full,
  output logic [7:0]            mode,
  output logic                  busy,
  output logic [3:0]            err_flags,
  input  logic                  err_clr
);

  localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] OP_REG_WR  = 8'h90;
  localparam logic [7:0] OP_REG_RD  = 8'h91;
  localparam logic [7:0] OP_FIFO_WR = 8'h92;
  localparam logic [7:0] OP_FIFO_RD = 8'h93;
  localparam logic [7:0] OP_MODE    = 8'h94;

  typedef enum logic [3:0] {
    S_IDLE, S_REG_ADDR, S_REG_WDATA, S_REG_RWAIT, S_CH,
    S_LEN_LO, S_LEN_HI, S_WR_DATA, S_RD_DATA, S_MODE_DATA
  } state_t;

  state_t                state_q;
  logic                  is_rd_q;     // read flavour of the current REG/FIFO opcode
  logic                  discard_q;   // bad channel: consume bytes, touch no FIFO
  logic [15:0]           len_q;
  logic [15:0]           cnt_q;
  logic [TMO_W-1:0]      tmo_q;
  logic [7:0]            tx_data_q;
  logic                  tx_valid_q;
  logic [REG_ADDR_W-1:0] reg_addr_q;
  logic                  reg_we_q;
  logic [7:0]            reg_wdata_q;
  logic [CH_W-1:0]       fifo_ch_q;
  logic [NUM_CH-1:0]     fifo_we_q;
  logic [7:0]            fifo_wdata_q;
  logic [NUM_CH-1:0]     fifo_rd_q;
  logic [7:0]            mode_q;
  logic [3:0]            err_q;

  logic                  tmo_hit;
  logic [NUM_CH-1:0]     ch_onehot;
  logic [7:0]            fifo_head;

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign tmo_hit = (TIMEOUT_CYC != 0) && !rx_valid &&
                   (state_q != S_IDLE) && (state_q != S_REG_RWAIT) &&
                   (tmo_q == TMO_W'(TIMEOUT_CYC));

  assign ch_onehot = NUM_CH'(1) << fifo_ch_q;
  assign fifo_head = fifo_rdata[8*fifo_ch_q +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      is_rd_q      <= 1'b0;
      discard_q    <= 1'b0;
      len_q        <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      reg_addr_q   <= '0;
      reg_we_q     <= 1'b0;
      reg_wdata_q  <= '0;
      fifo_ch_q    <= '0;
      fifo_we_q    <= '0;
      fifo_wdata_q <= '0;
      fifo_rd_q    <= '0;
      mode_q       <= '0;
      err_q        <= '0;
    end else begin
      reg_we_q   <= 1'b0;
      fifo_we_q  <= '0;
      fifo_rd_q  <= '0;
      tx_valid_q <= 1'b0;

      // Error sets below come later in the block, so they override this clear.
      if (err_clr) err_q <= '0;

      if (rx_valid || state_q == S_IDLE) tmo_q <= '0;
      else if (state_q != S_REG_RWAIT)   tmo_q <= tmo_q + 1'b1;

      if (tmo_hit) begin
        state_q  <= S_IDLE;
        err_q[1] <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: if (rx_valid) begin
            discard_q <= 1'b0;
            case (rx_data)
              OP_REG_WR:  begin is_rd_q <= 1'b0; state_q <= S_REG_ADDR; end
              OP_REG_RD:  begin is_rd_q <= 1'b1; state_q <= S_REG_ADDR; end
              OP_FIFO_WR: begin is_rd_q <= 1'b0; state_q <= S_CH; end
              OP_FIFO_RD: begin is_rd_q <= 1'b1; state_q <= S_CH; end
              OP_MODE:    state_q <= S_MODE_DATA;
              default:    err_q[0] <= 1'b1;
            endcase
          end
          S_REG_ADDR: if (rx_valid) begin
            reg_addr_q <= rx_data[REG_ADDR_W-1:0];
            if (int'(rx_data) >= NUM_REGS) err_q[0] <= 1'b1;
            state_q <= is_rd_q ? S_REG_RWAIT : S_REG_WDATA;
          end
          S_REG_WDATA: if (rx_valid) begin
            reg_wdata_q <= rx_data;
            reg_we_q    <= 1'b1;
            state_q     <= S_IDLE;
          end
          S_REG_RWAIT: begin
            tx_data_q  <= reg_rdata;
            tx_valid_q <= 1'b1;
            state_q    <= S_IDLE;
          end
          S_CH: if (rx_valid) begin
            fifo_ch_q <= rx_data[CH_W-1:0];
            if (int'(rx_data) >= NUM_CH) begin
              discard_q <= 1'b1;
              err_q[0]  <= 1'b1;
            end
            state_q <= S_LEN_LO;
          end
          S_LEN_LO: if (rx_valid) begin
            len_q[7:0] <= rx_data;
            state_q    <= S_LEN_HI;
          end
          S_LEN_HI: if (rx_valid) begin
            len_q[15:8] <= rx_data;
            cnt_q       <= '0;
            state_q     <= is_rd_q ? S_RD_DATA : S_WR_DATA;
          end
          S_WR_DATA: if (rx_valid) begin
            fifo_wdata_q <= rx_data;
            if (!discard_q) begin
              if (fifo_full[fifo_ch_q]) err_q[2] <= 1'b1;
              else                      fifo_we_q <= ch_onehot;
            end
            if (cnt_q == len_q) state_q <= S_IDLE;
            else                cnt_q   <= cnt_q + 16'd1;
          end
          S_RD_DATA: if (rx_valid) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= 8'h00;
            if (!discard_q) begin
              if (fifo_empty[fifo_ch_q]) begin
                err_q[3] <= 1'b1;
              end else begin
                tx_data_q <= fifo_head;
                fifo_rd_q <= ch_onehot;
              end
            end
            if (cnt_q == len_q) state_q <= S_IDLE;
            else                cnt_q   <= cnt_q + 16'd1;
          end
          S_MODE_DATA: if (rx_valid) begin
            mode_q  <= rx_data;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign reg_addr   = reg_addr_q;
  assign reg_we     = reg_we_q;
  assign reg_wdata  = reg_wdata_q;
  assign fifo_ch    = fifo_ch_q;
  assign fifo_we    = fifo_we_q;
  assign fifo_wdata = fifo_wdata_q;
  assign fifo_rd    = fifo_rd_q;
  assign mode       = mode_q;
  assign err_flags  = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_cmd_router.sv
// tb/tb_spi_cmd_router.sv - scoreboard bench for spi_cmd_router
module tb_spi_cmd_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [3:0]  reg_addr;
  logic        reg_we;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic [0:0]  fifo_ch;
  logic [1:0]  fifo_we;
  logic [7:0]  fifo_wdata;
  logic [1:0]  fifo_rd;
  logic [15:0] fifo_rdata;
  logic [1:0]  fifo_empty;
  logic [1:0]  fifo_full;
  logic [7:0]  mode;
  logic        busy;
  logic [3:0]  err_flags;
  logic        err_clr;

  spi_cmd_router #(
    .NUM_REGS(16), .REG_ADDR_W(4), .NUM_CH(2), .CH_W(1), .TIMEOUT_CYC(10)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .fifo_ch(fifo_ch), .fifo_we(fifo_we), .fifo_wdata(fifo_wdata),
    .fifo_rd(fifo_rd), .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .mode(mode), .busy(busy), .err_flags(err_flags), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // External register file
  logic [7:0] regs [16];
  always @(posedge clk) if (reg_we) regs[reg_addr] <= reg_wdata;
  assign reg_rdata = regs[reg_addr];

  // Channel 0 FWFT FIFO with preloadable contents; channel 1 always empty
  logic [7:0] fmem [4];
  logic [2:0] frd;
  logic [2:0] fwr = 3'd0;
  logic       full1 = 1'b0;
  always @(posedge clk) begin
    if (rst) frd <= 3'd0;
    else if (fifo_rd[0] && frd != fwr) frd <= frd + 3'd1;
  end
  assign fifo_empty = {1'b1, (frd == fwr)};
  assign fifo_rdata = {8'h00, fmem[frd[1:0]]};
  assign fifo_full  = {full1, 1'b0};

  // Scoreboard queues
  logic [11:0] exp_reg [$];   // {addr, data}
  logic [9:0]  exp_we  [$];   // {mask, data}
  logic [1:0]  exp_rd  [$];   // mask
  logic [7:0]  exp_tx  [$];
  int last_tx_cyc = 0;
  int last_edge   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL unexpected_%s: got strobe expected none", name);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (reg_we) begin
        if (exp_reg.size() == 0) unexpected("reg_we");
        else begin
          logic [11:0] e;
          e = exp_reg.pop_front();
          check("reg_addr", reg_addr, e[11:8]);
          check("reg_wdata", reg_wdata, e[7:0]);
        end
      end
      if (fifo_we != 2'b00) begin
        if (exp_we.size() == 0) unexpected("fifo_we");
        else begin
          logic [9:0] e;
          e = exp_we.pop_front();
          check("fifo_we", fifo_we, e[9:8]);
          check("fifo_wdata", fifo_wdata, e[7:0]);
        end
      end
      if (fifo_rd != 2'b00) begin
        if (exp_rd.size() == 0) unexpected("fifo_rd");
        else begin
          logic [1:0] e;
          e = exp_rd.pop_front();
          check("fifo_rd", fifo_rd, e);
        end
      end
      if (tx_valid) begin
        last_tx_cyc = cyc;
        if (exp_tx.size() == 0) unexpected("tx_valid");
        else begin
          logic [7:0] e;
          e = exp_tx.pop_front();
          check("tx_data", tx_data, e);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One byte strobe followed by one quiet cycle.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    last_edge = cyc;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx"}, {tx_valid, tx_data}, 0);
    check({tag, "_reg"}, {reg_we, reg_addr, reg_wdata}, 0);
    check({tag, "_fifo"}, {fifo_ch, fifo_we, fifo_rd, fifo_wdata}, 0);
    check({tag, "_mode"}, mode, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err_flags, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; err_clr = 1'b0;
    idle(3);
    check_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // Register write then read back
    exp_reg.push_back({4'h3, 8'h5A});
    send_byte(8'h90); send_byte(8'h03); send_byte(8'h5A);
    check("wr_busy", busy, 0);
    exp_tx.push_back(8'h5A);
    send_byte(8'h91); send_byte(8'h03);
    idle(2);
    check("rd_latency", last_tx_cyc - last_edge, 1);
    check("rd_err", err_flags, 4'b0000);

    // Address beyond NUM_REGS still completes but flags err[0]
    exp_tx.push_back(8'h5A);
    send_byte(8'h91); send_byte(8'h13);
    idle(2);
    check("addr_range_err", err_flags, 4'b0001);
    clear_err();
    check("err_clr", err_flags, 4'b0000);

    // Burst write to channel 1, four bytes
    exp_we.push_back({2'b10, 8'hA1});
    exp_we.push_back({2'b10, 8'hA2});
    exp_we.push_back({2'b10, 8'hA3});
    exp_we.push_back({2'b10, 8'hA4});
    send_byte(8'h92); send_byte(8'h01); send_byte(8'h03); send_byte(8'h00);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    check("burst_busy_mid", busy, 1);
    send_byte(8'hA4);
    check("burst_busy_end", busy, 0);
    check("burst_ch", fifo_ch, 1);

    // Burst read of three with only two words queued
    fmem[0] = 8'h11; fmem[1] = 8'h22; fwr = 3'd2;
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22); exp_tx.push_back(8'h00);
    exp_rd.push_back(2'b01); exp_rd.push_back(2'b01);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hEE); send_byte(8'hEE); send_byte(8'hEE);
    idle(1);
    check("underflow_err", err_flags, 4'b1000);
    check("underflow_busy", busy, 0);
    clear_err();

    // Overflow on full channel 1
    full1 = 1'b1;
    send_byte(8'h92); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h77);
    idle(1);
    check("overflow_err", err_flags, 4'b0100);
    full1 = 1'b0;
    clear_err();

    // Bad channel write: two bytes consumed, nothing pushed
    send_byte(8'h92); send_byte(8'h05); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hB1);
    check("badch_busy_mid", busy, 1);
    send_byte(8'hB2);
    check("badch_busy_end", busy, 0);
    check("badch_err", err_flags, 4'b0001);
    clear_err();

    // Bad channel read returns zero, no pop
    exp_tx.push_back(8'h00);
    send_byte(8'h93); send_byte(8'h07); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hEE);
    idle(1);
    check("badch_rd_err", err_flags, 4'b0001);
    clear_err();

    // Unknown opcode
    send_byte(8'h55);
    check("badop_err", err_flags, 4'b0001);
    check("badop_busy", busy, 0);
    clear_err();

    // Inter-byte timeout after the channel byte
    send_byte(8'h92); send_byte(8'h00);
    idle(5);
    check("tmo_busy_mid", busy, 1);
    idle(6);
    check("tmo_busy_end", busy, 0);
    check("tmo_err", err_flags, 4'b0010);
    send_byte(8'h94); send_byte(8'h3C);
    check("mode_3c", mode, 8'h3C);
    clear_err();

    // Reset in the middle of a burst write
    exp_we.push_back({2'b01, 8'hC1});
    send_byte(8'h92); send_byte(8'h00); send_byte(8'h03); send_byte(8'h00);
    send_byte(8'hC1);
    check("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    send_byte(8'h94); send_byte(8'h01);
    check("mode_01", mode, 8'h01);

    idle(3);
    check("left_reg", exp_reg.size(), 0);
    check("left_we", exp_we.size(), 0);
    check("left_rd", exp_rd.size(), 0);
    check("left_tx", exp_tx.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_cmd_router.md
Name: spi_cmd_router

Overview:
Parametrised next-generation SPI command decoder. Sits between the SPI slave byte interface and the FPGA's control registers and per-channel sample FIFOs. Decodes opcode-framed byte streams into:
- register reads and writes
- multi-byte burst writes and reads on one of NUM_CH FIFOs
- mode writes

Adds explicit length framing, channel selection, an inter-byte timeout and sticky error flags.

Parameters:
NUM_REGS, 16, number of addressable 8-bit control registers (external storage)
REG_ADDR_W, 4, register address width; NUM_REGS <= 2**REG_ADDR_W
NUM_CH, 2, number of FIFO channels (1..8)
CH_W, 1, channel index width, $clog2(NUM_CH) minimum 1
TIMEOUT_CYC, 65535, idle clk cycles allowed between bytes inside a command; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_data  in  8  received SPI byte
rx_valid  in  1  one-cycle strobe; rx_data is valid
tx_data  out  8  registered byte for the SPI slave to shift out next
tx_valid  out  1  one-cycle strobe; tx_data is loaded
reg_addr  out  REG_ADDR_W  register address, registered
reg_we  out  1  one-cycle register write strobe
reg_wdata  out  8  register write data
reg_rdata  in  8  combinational read data for reg_addr
fifo_ch  out  CH_W  active channel index, registered
fifo_we  out  NUM_CH  one-hot write strobes
fifo_wdata  out  8  FIFO write data
fifo_rd  out  NUM_CH  one-hot pop strobes; FIFOs are first-word-fall-through
fifo_rdata  in  8*NUM_CH  head word per channel; channel k is bits [8k+7:8k]
fifo_empty  in  NUM_CH  per-channel empty
fifo_full  in  NUM_CH  per-channel full
mode  out  8  mode register
busy  out  1  high whenever state is not IDLE
err_flags  out  4  sticky errors: [0] bad opcode/channel, [1] timeout, [2] overflow, [3] underflow
err_clr  in  1  clears err_flags

Behaviour:
- Reset values: every output is 0, state is IDLE, timeout counter is 0. Reset asserted mid-command aborts immediately with no strobes.
- Strobes (reg_we, fifo_we, fifo_rd, tx_valid) are high for exactly one cycle.
- Opcodes, decoded in IDLE:
  - 0x90 REG_WR: addr byte, then data byte.
  - 0x91 REG_RD: addr byte.
  - 0x92 FIFO_WR: ch, len_lo, len_hi, then len+1 data bytes.
  - 0x93 FIFO_RD: ch, len_lo, len_hi, then len+1 dummy bytes.
  - 0x94 MODE: one data byte.
  - Any other byte in IDLE: stay in IDLE, set err[0].
- States: IDLE, REG_ADDR, REG_WDATA, REG_RWAIT, CH, LEN_LO, LEN_HI, WR_DATA, RD_DATA, MODE_DATA.
- REG_ADDR
  - Address byte at cycle N: reg_addr <= rx_data[REG_ADDR_W-1:0] at N+1.
  - REG_WR then goes to REG_WDATA.
  - REG_RD goes to REG_RWAIT. At N+2: tx_data <= reg_rdata, tx_valid = 1, return to IDLE. No rx byte is needed.
- REG_WDATA: byte at N; at N+1 reg_wdata = byte, reg_we = 1; go to IDLE.
- Address >= NUM_REGS: the access still completes, and err[0] is set.
- CH: fifo_ch <= rx_data[CH_W-1:0].
  - If rx_data >= NUM_CH, set err[0] and set an internal discard flag for the rest of the command.
  - Discard effect: no FIFO strobes; reads return 0x00.
- Length = {len_hi, len_lo}, 16-bit; the transfer is len+1 bytes (0x0000 means 1 byte, 0xFFFF means 65536). The byte counter counts up and the command ends when counter == length. No wrap is possible.
- WR_DATA: byte at N; at N+1 fifo_wdata = byte.
  - fifo_we[ch] = 1 only if !fifo_full[ch] at N.
  - If full: byte dropped, err[2] set.
- RD_DATA: dummy byte at N; at N+1 tx_valid = 1.
  - Not empty: tx_data = fifo_rdata[ch] sampled at N, and fifo_rd[ch] = 1.
  - Empty: tx_data = 0x00, no pop, err[3] set.
- MODE_DATA: byte at N; mode <= byte at N+1; go to IDLE.
- After the last byte of any command the state is IDLE on the next cycle. The next opcode may arrive as early as the cycle after that.
- Timeout:
  - The counter clears on every rx_valid and increments in any non-IDLE state except REG_RWAIT.
  - When the counter == TIMEOUT_CYC and TIMEOUT_CYC != 0: go to IDLE, set err[1], issue no strobe.
  - rx_valid in the same cycle as the expiry: the byte is processed and there is no timeout.
- err_clr clears the flags. An error event in the same cycle as err_clr wins, so that flag stays set.
- busy = (state != IDLE).

Test Plan:
- Register write and read: 90 03 5A -> reg_we one cycle with reg_addr=3, reg_wdata=0x5A. Then 91 03 with reg_rdata=0x5A -> tx_valid 2 cycles after the addr byte, tx_data=0x5A.
- Burst write: 92 01 03 00 A1 A2 A3 A4 -> exactly 4 fifo_we pulses, each =2'b10, carrying A1..A4; busy falls after the 4th byte.
- Burst read with underflow: channel 0 holds 2 words (11, 22); send 93 00 02 00 xx xx xx -> tx_data 11, 22, 00; 2 fifo_rd pulses; err[3] set.
- Overflow and bad channel:
  - fifo_full[1]=1 during a 92 01 00 00 77 command -> no fifo_we, err[2]=1.
  - 92 05 ... with NUM_CH=2 -> err[0]=1, no strobes, len+1 bytes consumed, then IDLE.
- Timeout: TIMEOUT_CYC=10; send 92 00 then stall 10 cycles -> IDLE, err[1]=1. Next 94 3C -> mode=0x3C.
- Reset mid-burst: assert rst during WR_DATA -> all outputs 0 asynchronously, state IDLE. After release, 94 01 -> mode=0x01.
